// File: rtl/alucont_md_if.sv
// alucont_md_if: execute-stage bundle between the main controller and the ALU-control / mul-div block.
// Latency: none. This file only groups the signals.
// Backpressure: the block raises stall toward the controller. The controller side is the master modport.
interface alucont_md_if #(
  parameter int WIDTH = 32
);
  logic             ex_valid;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       gout;
  logic             stall;
  logic             md_busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_rd;

  modport master (
    output ex_valid, aluop, funct, a, b,
    input  gout, stall, md_busy, hi, lo, hilo_rd
  );

  modport slave (
    input  ex_valid, aluop, funct, a, b,
    output gout, stall, md_busy, hi, lo, hilo_rd
  );
endinterface

// File: rtl/alucont_md.sv
// alucont_md: ALU control decode plus an iterative mult/multu/div/divu sequencer with HI/LO registers.
// Latency: gout and stall are combinational. HI/LO are written WIDTH+1 edges after the start edge.
// Backpressure: stall holds execute for mul/div or HI/LO ops while busy. Optional mthi/mtlo build: HILO_WRITE_EN.
module alucont_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  alucont_md_if.slave  bus
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;    // product high half / partial remainder
  logic [WIDTH-1:0]   r_quo;    // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0]   r_div;    // multiplicand / divisor magnitude
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic w_rtype, w_md, w_hf, w_mthi, w_mtlo, w_busy, w_start, w_signed;
  logic w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_rtype = (bus.aluop == 2'b10);
  assign w_md    = w_rtype & ((bus.funct == F_MULT) | (bus.funct == F_MULTU) |
                              (bus.funct == F_DIV)  | (bus.funct == F_DIVU));
`ifdef HILO_WRITE_EN
  assign w_mthi  = w_rtype & (bus.funct == 6'b010001);
  assign w_mtlo  = w_rtype & (bus.funct == 6'b010011);
`else
  assign w_mthi  = 1'b0;
  assign w_mtlo  = 1'b0;
`endif
  assign w_hf     = (w_rtype & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO))) | w_mthi | w_mtlo;
  assign w_busy   = (r_state != S_IDLE);
  assign w_start  = bus.ex_valid & w_md & ~w_busy;
  // funct[0] clear selects the signed variant (mult, div); funct[1] selects divide.
  assign w_signed = ~bus.funct[0];

  assign w_a_neg = w_signed & bus.a[WIDTH-1];
  assign w_b_neg = w_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.a + ONE) : bus.a;
  assign w_b_mag = w_b_neg ? (~bus.b + ONE) : bus.b;

  // Shift-add step: conditionally add the multiplicand, then shift {rem,quo} right one bit.
  assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_div} : {(WIDTH+1){1'b0}});
  // Restoring divide step: bring in the next dividend bit and trial-subtract the divisor.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[WIDTH-1:0] - r_div;

  assign w_prod     = {r_rem, r_quo};
  assign w_prod_fix = r_neg_q ? (~w_prod + ONE2) : w_prod;
  // A zero divisor yields all-ones quotient regardless of sign; the remainder path already restores a.
  assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~r_quo + ONE) : r_quo);
  assign w_rem_fix  = r_neg_r ? (~r_rem + ONE) : r_rem;

  assign bus.stall   = bus.ex_valid & w_busy & (w_md | w_hf);
  assign bus.md_busy = w_busy;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.hilo_rd = (bus.funct == F_MFHI) ? r_hi : r_lo;

  // ALU control decode, independent of valid and sequencer state.
  always_comb begin
    bus.gout = 3'b010;
    if (w_rtype) begin
      case (bus.funct)
        F_SUB:   bus.gout = 3'b110;
        F_AND:   bus.gout = 3'b000;
        F_OR:    bus.gout = 3'b001;
        F_SLT:   bus.gout = 3'b111;
        F_ADD:   bus.gout = 3'b010;
        default: bus.gout = 3'b010;
      endcase
    end else if (bus.aluop == 2'b01) begin
      bus.gout = 3'b110;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: start on an accepted md op, iterate WIDTH times, then one fix-up edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = bus.funct[1] ? S_DIV : S_MUL;
      S_MUL:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_DIV:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Iteration datapath: latch magnitudes and signs at start, then one bit per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_cnt    <= CNT_W'(WIDTH);
          r_rem    <= '0;
          r_quo    <= w_a_mag;
          r_div    <= w_b_mag;
          r_is_div <= bus.funct[1];
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg & bus.funct[1];
          r_dz     <= bus.funct[1] & (bus.b == '0);
        end
        S_MUL: begin
          r_rem <= w_mul_sum[WIDTH:1];
          r_quo <= {w_mul_sum[0], r_quo[WIDTH-1:1]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: written only by the fix-up edge (or, optionally, mthi/mtlo while idle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      if (r_is_div) begin
        r_lo <= w_quo_fix;
        r_hi <= w_rem_fix;
      end else begin
        {r_hi, r_lo} <= w_prod_fix;
      end
    end else if (bus.ex_valid & ~w_busy) begin
      if (w_mthi) r_hi <= bus.a;
      if (w_mtlo) r_lo <= bus.a;
    end
  end

endmodule

// File: tb/tb_alucont_md.sv
// tb_alucont_md: directed checks of decode, mul/div results, busy/stall timing and async reset.
// Latency: inputs change 1 time unit after each rising edge and outputs are sampled before the next edge.
// Backpressure: stall counts are compared against hand-derived cycle numbers.
module tb_alucont_md;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  alucont_md_if #(.WIDTH(32)) bus();

  alucont_md #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.ex_valid = v;
    bus.aluop    = op;
    bus.funct    = f;
    bus.a        = av;
    bus.b        = bv;
  endtask

  // Present an md op for exactly one cycle so the next edge starts it.
  task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
    drive(1'b1, 2'b10, f, av, bv);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
  endtask

  // Count busy cycles until idle; a stuck sequencer gives 200, which never matches.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.md_busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 2'b10, F_MULT, 32'd3, 32'd4);
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.md_busy); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h want=0/0", bus.hi, bus.lo); end
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_decode;
    logic [1:0] ops [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [5:0] fns [10] = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b100000,
                             6'b100100, 6'b100010, 6'b011000, 6'b101010, 6'b111111};
    logic [2:0] exp [10] = '{3'b111, 3'b110, 3'b000, 3'b001, 3'b010,
                             3'b110, 3'b010, 3'b010, 3'b010, 3'b010};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, ops[i], fns[i], 32'd0, 32'd0);
      #1;
      total++;
      if (bus.gout !== exp[i]) begin
        bad++;
        $display("FAIL decode[%0d] aluop=%b funct=%b got=%b want=%b", i, ops[i], fns[i], bus.gout, exp[i]);
      end
    end
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  // Run one md op to completion and compare latency plus HI/LO.
  task automatic test_md(input string name, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(f, av, bv);
    wait_idle(n);
    total++; if (n != 33) begin bad++; $display("FAIL %s_busy got=%0d want=33", name, n); end
    total++; if (bus.hi !== ehi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, bus.hi, ehi); end
    total++; if (bus.lo !== elo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, bus.lo, elo); end
  endtask

  task automatic test_stall_mflo;
    int n;
    issue(F_MULT, 32'd6, 32'd7);
    // Cycles 1..4: an add while busy must pass through.
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 2'b10, F_ADD, 32'd1, 32'd2);
      #1;
      total++;
      if (bus.stall !== 1'b0 || bus.gout !== 3'b010) begin
        bad++;
        $display("FAIL add_busy cyc=%0d stall=%b gout=%b want stall=0 gout=010", c, bus.stall, bus.gout);
      end
      @(posedge clk); #1;
    end
    drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n != 29) begin bad++; $display("FAIL mflo_stall got=%0d want=29", n); end
    total++; if (bus.hilo_rd !== 32'd42) begin bad++; $display("FAIL mflo_rd got=%h want=0000002a", bus.hilo_rd); end
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(F_MULTU, 32'd3, 32'd5);
    drive(1'b1, 2'b10, F_MULT, 32'd6, 32'd7);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n != 33) begin bad++; $display("FAIL b2b_stall got=%0d want=33", n); end
    total++; if (bus.lo !== 32'd15 || bus.md_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_first got lo=%h busy=%b want lo=0000000f busy=0", bus.lo, bus.md_busy);
    end
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b want=1", bus.md_busy); end
    wait_idle(n);
    total++; if (n != 33) begin bad++; $display("FAIL b2b_busy2 got=%0d want=33", n); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      bad++; $display("FAIL b2b_second got=%h/%h want=00000000/0000002a", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_div;
    issue(F_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo got=%h/%h want=0/0", bus.hi, bus.lo); end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus.md_busy); end
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_md("post_rst_multu", F_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    test_reset;
    test_decode;
    test_md("multu_max",  F_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
    test_md("mult_neg",   F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    test_md("div_neg",    F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    test_md("divu_zero",  F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
    test_md("div_zero",   F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    test_md("div_minm1",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    test_stall_mflo;
    test_back_to_back;
    test_reset_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alucont_md.md
Name: alucont_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes aluop/funct into the 3-bit ALU control code, same encoding as today.
- Adds an iterative multiply/divide sequencer with HI/LO registers for mult, multu, div, divu, mfhi and mflo.
- Sits in the execute stage beside the ALU. Returns a stall to the main controller when a HI/LO consumer or a second mul/div arrives while the sequencer is busy.

Parameters:
WIDTH, 32, operand, HI and LO width (>=4, even)
CNT_W, 6, iteration counter width (must hold WIDTH+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  instruction in execute is valid this cycle
aluop  in  2  main-control ALU op (00 lw/sw, 01 beq, 10 R-type, 11 reserved)
funct  in  6  instruction funct field
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand
gout  out  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt
stall  out  1  hold execute stage this cycle
md_busy  out  1  sequencer running
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
hilo_rd  out  WIDTH  hi when funct=010000 (mfhi), otherwise lo

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset. Reset forces: state IDLE, hi=0, lo=0, counter=0, md_busy=0. Reset mid-operation aborts the running operation with no partial HI/LO write.
- gout is purely combinational and independent of ex_valid and state:
  - aluop 00 -> 010; aluop 01 -> 110; aluop 11 -> 010.
  - aluop 10, by funct: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; any other funct, including mul/div/mf -> 010.
- md op: aluop=10 with funct 011000 mult, 011001 multu, 011010 div or 011011 divu. hf op: funct 010000 or 010010.
- stall = ex_valid & md_busy & (md op | hf op). It is combinational and never asserted while IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL/DIV on an edge where ex_valid & md op & ~md_busy. That edge latches |a|, |b| (signed ops only), the result signs and the op kind, and loads counter=WIDTH. The issuing instruction is not stalled and retires.
  - MUL: radix-2 shift-add, one bit per edge, counter decrements.
  - DIV: restoring divide, one quotient bit per edge.
  - counter=1 at an edge -> FIX.
  - FIX: apply sign correction, write hi/lo, go to IDLE.
- Latency: the start edge is E0. HI/LO are written at edge E(WIDTH+1). md_busy is 1 from after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
- mult/multu: {hi,lo} = full 2*WIDTH-bit product.
- div/divu: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b=0): lo = all ones, hi = a, for both signed and unsigned. No exception.
- Signed min / -1: lo = min (wraps), hi = 0.
- hilo_rd always reflects the current registers. Following a stall, the first non-stalled cycle sees the new value.
- An md op arriving while busy is stalled, then accepted on the first idle edge. No queueing.

Optional Feature:
- Macro HILO_WRITE_EN.
- Defined: funct 010001 (mthi) and 010011 (mtlo) with aluop=10 & ex_valid write a into hi or lo at the edge. Both count as hf ops for stall, so they are stalled while busy. gout=010.
- Undefined: those functs only decode gout=010; hi/lo untouched, no stall.

Test Plan:
- Decode: aluop=10 with funct 101010/100010/100100/100101/100000 -> gout 111/110/000/001/010; aluop=01 -> 110; aluop=00 -> 010; aluop=10 with funct 011000 -> 010.
- multu a=0xFFFFFFFF b=2 -> md_busy high exactly 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mflo issued 5 cycles after mult 6*7 -> stall high 29 cycles; on the first non-stalled cycle hilo_rd=42. An add during busy is never stalled.
- reset pulsed mid-divide (not on a clock edge) -> hi=lo=0 and md_busy=0 immediately. A following multu 3*5 completes normally with lo=15.
